// File: rtl/axi_lite_pkt_pkg.sv
// rtl/axi_lite_pkt_pkg.sv - shared types and constants for the AXI-Lite packet master
package axi_lite_pkt_pkg;

  // Top-level sequencing: data write, its B wait, commit write, its B wait, report.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_D_WR,
    ST_D_B,
    ST_C_WR,
    ST_C_B,
    ST_DONE
  } state_e;

  localparam logic [7:0] DEF_COMMIT_ADDR = 8'h04;

  // Bit positions inside done_resp.
  localparam int RESP_DATA   = 1;
  localparam int RESP_COMMIT = 0;

endpackage

// File: rtl/axi_lite_wr_xact.sv
// rtl/axi_lite_wr_xact.sv - one AXI-Lite AW/W/B write transaction with B-wait timeout
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   start, start_addr, start_data  launch a write (accepted when idle or in the
//                                  same cycle the previous B wait completes)
//   wr_done                        AW and W both finish handshaking this cycle
//   xact_done                      B wait ends this cycle (response or timeout)
//   xact_resp, xact_timeout        result qualifying xact_done
//   aw_*, w_*, b_*                 AXI-Lite write channels (outputs registered)
module axi_lite_wr_xact #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [DATA_W-1:0] start_data,
  output logic              wr_done,
  output logic              xact_done,
  output logic              xact_resp,
  output logic              xact_timeout,
  output logic [ADDR_W-1:0] aw_addr,
  output logic              aw_valid,
  input  logic              aw_ready,
  output logic [DATA_W-1:0] w_data,
  output logic              w_valid,
  input  logic              w_ready,
  input  logic              b_response,
  input  logic              b_valid,
  output logic              b_ready
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic              aw_valid_q, aw_valid_d;
  logic              w_valid_q, w_valid_d;
  logic              b_ready_q, b_ready_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              aw_pending, w_pending, expired;

  // A valid stays up until its own handshake; the two channels are independent.
  assign aw_pending   = aw_valid_q && !aw_ready;
  assign w_pending    = w_valid_q && !w_ready;
  assign wr_done      = (aw_valid_q || w_valid_q) && !aw_pending && !w_pending;
  assign expired      = (cnt_q == CNT_LAST);
  // b_valid on the expiry cycle wins over the timeout.
  assign xact_done    = b_ready_q && (b_valid || expired);
  assign xact_resp    = b_ready_q && b_valid && b_response;
  assign xact_timeout = b_ready_q && !b_valid && expired;

  always_comb begin
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    aw_valid_d = aw_pending;
    w_valid_d  = w_pending;
    b_ready_d  = b_ready_q && !xact_done;
    cnt_d      = cnt_q;
    if (b_ready_q && !xact_done) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (wr_done) begin
      b_ready_d = 1'b1;
      cnt_d     = '0;
    end
    if (start) begin
      aw_addr_d  = start_addr;
      w_data_d   = start_data;
      aw_valid_d = 1'b1;
      w_valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_ready_q  <= b_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  assign aw_addr  = aw_addr_q;
  assign aw_valid = aw_valid_q;
  assign w_data   = w_data_q;
  assign w_valid  = w_valid_q;
  assign b_ready  = b_ready_q;

endmodule

// File: rtl/axi_lite_pkt_master.sv
// rtl/axi_lite_pkt_master.sv - AXI-Lite initiator issuing a data write plus commit write per packet
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   req_valid/req_ready/req_addr/req_data  packet request (ready only in IDLE)
//   done_valid/done_resp/done_timeout   one-cycle completion report; resp and
//                                       timeout hold until the next accept
//   aw_*, w_*, b_*                      AXI-Lite write channels to the slave
module axi_lite_pkt_master
  import axi_lite_pkt_pkg::*;
#(
  parameter int                ADDR_W         = 8,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] COMMIT_ADDR    = ADDR_W'(DEF_COMMIT_ADDR),
  parameter int                TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              done_valid,
  output logic [1:0]        done_resp,
  output logic              done_timeout,
  output logic [ADDR_W-1:0] aw_addr,
  output logic              aw_valid,
  input  logic              aw_ready,
  output logic [DATA_W-1:0] w_data,
  output logic              w_valid,
  input  logic              w_ready,
  input  logic              b_response,
  input  logic              b_valid,
  output logic              b_ready
);

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              done_valid_q, done_valid_d;
  logic [1:0]        done_resp_q, done_resp_d;
  logic              done_timeout_q, done_timeout_d;

  logic              x_start;
  logic [ADDR_W-1:0] x_addr;
  logic [DATA_W-1:0] x_data;
  logic              x_wr_done, x_done, x_resp, x_timeout;

  axi_lite_wr_xact #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_xact (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (x_start),
    .start_addr   (x_addr),
    .start_data   (x_data),
    .wr_done      (x_wr_done),
    .xact_done    (x_done),
    .xact_resp    (x_resp),
    .xact_timeout (x_timeout),
    .aw_addr      (aw_addr),
    .aw_valid     (aw_valid),
    .aw_ready     (aw_ready),
    .w_data       (w_data),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .b_response   (b_response),
    .b_valid      (b_valid),
    .b_ready      (b_ready)
  );

  always_comb begin
    state_d        = state_q;
    done_valid_d   = 1'b0;
    done_resp_d    = done_resp_q;
    done_timeout_d = done_timeout_q;
    x_start        = 1'b0;
    x_addr         = req_addr;
    x_data         = req_data;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          x_start        = 1'b1;
          done_resp_d    = 2'b00;
          done_timeout_d = 1'b0;
          state_d        = ST_D_WR;
        end
      end
      ST_D_WR: if (x_wr_done) state_d = ST_D_B;
      ST_D_B: begin
        if (x_done) begin
          done_resp_d[RESP_DATA] = x_resp;
          if (x_timeout) begin
            // Data write never answered: skip the commit.
            done_timeout_d = 1'b1;
            done_valid_d   = 1'b1;
            state_d        = ST_DONE;
          end else begin
            // Launch the commit in the same edge so its valids rise next cycle.
            x_start = 1'b1;
            x_addr  = COMMIT_ADDR;
            x_data  = '0;
            state_d = ST_C_WR;
          end
        end
      end
      ST_C_WR: if (x_wr_done) state_d = ST_C_B;
      ST_C_B: begin
        if (x_done) begin
          done_resp_d[RESP_COMMIT] = x_resp;
          done_timeout_d           = x_timeout;
          done_valid_d             = 1'b1;
          state_d                  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      req_ready_q    <= 1'b1;
      done_valid_q   <= 1'b0;
      done_resp_q    <= 2'b00;
      done_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_ready_q    <= req_ready_d;
      done_valid_q   <= done_valid_d;
      done_resp_q    <= done_resp_d;
      done_timeout_q <= done_timeout_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign done_valid   = done_valid_q;
  assign done_resp    = done_resp_q;
  assign done_timeout = done_timeout_q;

endmodule

// File: tb/tb_axi_lite_pkt_master.sv
// tb/tb_axi_lite_pkt_master.sv - directed self-checking bench for axi_lite_pkt_master
module tb_axi_lite_pkt_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_addr;
  logic [31:0] req_data;
  logic        done_valid;
  logic [1:0]  done_resp;
  logic        done_timeout;
  logic [7:0]  aw_addr;
  logic        aw_valid;
  logic        aw_ready;
  logic [31:0] w_data;
  logic        w_valid;
  logic        w_ready;
  logic        b_response;
  logic        b_valid;
  logic        b_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_lite_pkt_master #(
    .ADDR_W         (8),
    .DATA_W         (32),
    .COMMIT_ADDR    (8'h04),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .done_valid   (done_valid),
    .done_resp    (done_resp),
    .done_timeout (done_timeout),
    .aw_addr      (aw_addr),
    .aw_valid     (aw_valid),
    .aw_ready     (aw_ready),
    .w_data       (w_data),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .b_response   (b_response),
    .b_valid      (b_valid),
    .b_ready      (b_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int br, cseen, done_at, rr, dv, av;
    logic [1:0] cap_resp;
    logic       cap_to;

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0;
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_response = 1'b0;
    tick(); tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_aw_valid", aw_valid, 0);
    check("rst_w_valid", w_valid, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_done_valid", done_valid, 0);
    check("rst_done_resp", done_resp, 0);
    check("rst_done_timeout", done_timeout, 0);
    check("rst_aw_addr", aw_addr, 0);
    check("rst_w_data", w_data, 0);
    rst_n = 1'b1;
    tick();

    // Zero-wait slave; data response 1, commit response 0.
    req_addr = 8'h00; req_data = 32'hA5001122; req_valid = 1'b1;
    aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1; b_response = 1'b1;
    tick();
    req_valid = 1'b0;
    check("t1_c1_aw_valid", aw_valid, 1);
    check("t1_c1_w_valid", w_valid, 1);
    check("t1_c1_aw_addr", aw_addr, 8'h00);
    check("t1_c1_w_data", w_data, 32'hA5001122);
    check("t1_c1_req_ready", req_ready, 0);
    check("t1_c1_b_ready", b_ready, 0);
    tick();
    check("t1_c2_b_ready", b_ready, 1);
    check("t1_c2_aw_valid", aw_valid, 0);
    check("t1_c2_w_valid", w_valid, 0);
    tick();
    b_response = 1'b0;
    check("t1_c3_aw_valid", aw_valid, 1);
    check("t1_c3_aw_addr", aw_addr, 8'h04);
    check("t1_c3_w_data", w_data, 32'h0);
    check("t1_c3_b_ready", b_ready, 0);
    tick();
    check("t1_c4_b_ready", b_ready, 1);
    tick();
    check("t1_c5_done_valid", done_valid, 1);
    check("t1_c5_done_resp", done_resp, 2'b10);
    check("t1_c5_done_timeout", done_timeout, 0);
    check("t1_c5_req_ready", req_ready, 0);
    tick();
    check("t1_c6_done_valid", done_valid, 0);
    check("t1_c6_req_ready", req_ready, 1);
    check("t1_c6_done_resp_hold", done_resp, 2'b10);

    // aw_ready delayed, w_ready immediate.
    req_addr = 8'h10; req_data = 32'h12345678; req_valid = 1'b1;
    aw_ready = 1'b0; w_ready = 1'b1; b_valid = 1'b0;
    tick();
    req_valid = 1'b0;
    check("t2_c1_aw_valid", aw_valid, 1);
    check("t2_c1_w_valid", w_valid, 1);
    tick();
    check("t2_c2_w_valid", w_valid, 0);
    check("t2_c2_aw_valid", aw_valid, 1);
    check("t2_c2_aw_addr", aw_addr, 8'h10);
    tick();
    check("t2_c3_aw_valid", aw_valid, 1);
    check("t2_c3_aw_addr", aw_addr, 8'h10);
    check("t2_c3_b_ready", b_ready, 0);
    aw_ready = 1'b1;
    tick();
    check("t2_c4_aw_valid", aw_valid, 0);
    check("t2_c4_b_ready", b_ready, 1);
    aw_ready = 1'b0; b_valid = 1'b1; b_response = 1'b0;
    tick();
    b_valid = 1'b0;
    check("t2_c5_aw_valid", aw_valid, 1);
    check("t2_c5_w_valid", w_valid, 1);
    check("t2_c5_aw_addr", aw_addr, 8'h04);
    tick();
    check("t2_c6_w_valid", w_valid, 0);
    check("t2_c6_aw_valid", aw_valid, 1);
    aw_ready = 1'b1;
    tick();
    check("t2_c7_aw_valid", aw_valid, 0);
    check("t2_c7_b_ready", b_ready, 1);
    b_valid = 1'b1; b_response = 1'b1;
    tick();
    b_valid = 1'b0;
    check("t2_c8_done_valid", done_valid, 1);
    check("t2_c8_done_resp", done_resp, 2'b01);
    check("t2_c8_done_timeout", done_timeout, 0);
    tick();

    // Data write never answered: timeout after 16 b_ready cycles, no commit.
    req_addr = 8'h20; req_data = 32'h00C0FFEE; req_valid = 1'b1;
    aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b0;
    tick();
    req_valid = 1'b0;
    check("t3_c1_aw_valid", aw_valid, 1);
    br = 0; cseen = 0; done_at = 0; cap_resp = 2'b11; cap_to = 1'b0;
    for (int c = 2; c <= 30 && done_at == 0; c++) begin
      tick();
      if (b_ready) br++;
      if (aw_valid) cseen++;
      if (done_valid) begin
        done_at  = c;
        cap_resp = done_resp;
        cap_to   = done_timeout;
      end
    end
    check("t3_done_cycle", done_at, 18);
    check("t3_b_ready_cycles", br, 16);
    check("t3_commit_issued", cseen, 0);
    check("t3_done_timeout", cap_to, 1);
    check("t3_done_resp", cap_resp, 2'b00);
    tick();

    // Commit response arrives on the expiry cycle.
    req_addr = 8'h30; req_data = 32'h5A5A5A5A; req_valid = 1'b1;
    aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    b_valid = 1'b1; b_response = 1'b1;
    tick();
    b_valid = 1'b0;
    check("t4_c3_aw_addr", aw_addr, 8'h04);
    tick();
    for (int c = 5; c <= 19; c++) tick();
    check("t4_c19_b_ready", b_ready, 1);
    check("t4_c19_done_valid", done_valid, 0);
    b_valid = 1'b1; b_response = 1'b1;
    tick();
    b_valid = 1'b0;
    check("t4_c20_done_valid", done_valid, 1);
    check("t4_c20_done_resp", done_resp, 2'b11);
    check("t4_c20_done_timeout", done_timeout, 0);
    tick();

    // Back-to-back requests with req_valid held high.
    req_addr = 8'h00; req_data = 32'hA5001122; req_valid = 1'b1;
    aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1; b_response = 1'b0;
    tick();
    req_addr = 8'h08; req_data = 32'hFF334455;
    check("t5_c1_aw_addr", aw_addr, 8'h00);
    check("t5_c1_w_data", w_data, 32'hA5001122);
    rr = int'(req_ready);
    for (int c = 2; c <= 5; c++) begin
      tick();
      rr += int'(req_ready);
    end
    check("t5_req_ready_during_first", rr, 0);
    check("t5_c5_done_valid", done_valid, 1);
    tick();
    check("t5_c6_req_ready", req_ready, 1);
    check("t5_c6_done_valid", done_valid, 0);
    tick();
    req_valid = 1'b0;
    check("t5_c7_aw_addr", aw_addr, 8'h08);
    check("t5_c7_w_data", w_data, 32'hFF334455);
    check("t5_c7_req_ready", req_ready, 0);
    for (int c = 8; c <= 11; c++) tick();
    check("t5_c11_done_valid", done_valid, 1);
    check("t5_c11_done_resp", done_resp, 2'b00);
    tick();

    // Reset pulse while the commit write is pending.
    req_addr = 8'h40; req_data = 32'h11112222; req_valid = 1'b1;
    aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1; b_response = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    aw_ready = 1'b0; w_ready = 1'b0;
    check("t6_c3_aw_valid", aw_valid, 1);
    check("t6_c3_aw_addr", aw_addr, 8'h04);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_aw_valid", aw_valid, 0);
    check("t6_async_w_valid", w_valid, 0);
    check("t6_async_b_ready", b_ready, 0);
    check("t6_async_req_ready", req_ready, 1);
    tick();
    tick();
    rst_n = 1'b1;
    aw_ready = 1'b1; w_ready = 1'b1;
    dv = 0; av = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      dv += int'(done_valid);
      av += int'(aw_valid);
    end
    check("t6_no_done_after_reset", dv, 0);
    check("t6_no_valid_after_reset", av, 0);
    req_addr = 8'h0C; req_data = 32'h0BADF00D; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("t6_r_c1_aw_addr", aw_addr, 8'h0C);
    check("t6_r_c1_w_data", w_data, 32'h0BADF00D);
    for (int c = 2; c <= 5; c++) tick();
    check("t6_r_c5_done_valid", done_valid, 1);
    check("t6_r_c5_done_resp", done_resp, 2'b11);
    check("t6_r_c5_done_timeout", done_timeout, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
